// File: rtl/debug_reg_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : debug_reg_dump_if
// Purpose  : Register-bank debug read port plus byte-stream TX handshake.
// Revision : 1.0
// ============================================================================
interface debug_reg_dump_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8
);
    logic                o_ctrl_read_debug_reg;
    logic [NB_REG-1:0]   o_addr_debug_unit;
    logic [NB_DATA-1:0]  i_data_reg_debug_unit;
    logic                o_tx_valid;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                i_tx_ready;

    modport master (
        output o_ctrl_read_debug_reg,
        output o_addr_debug_unit,
        input  i_data_reg_debug_unit,
        output o_tx_valid,
        output o_tx_data,
        input  i_tx_ready
    );

    modport slave (
        input  o_ctrl_read_debug_reg,
        input  o_addr_debug_unit,
        output i_data_reg_debug_unit,
        input  o_tx_valid,
        input  o_tx_data,
        output i_tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/debug_reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : debug_reg_dump
// Purpose  : Walks the register bank via the debug port and streams each
//            register MSB-byte first over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module debug_reg_dump #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int N_REGS       = 32,
    parameter int NB_BYTE      = 8,
    parameter int READ_LATENCY = 1
) (
    input  wire logic        i_clock,
    input  wire logic        i_reset,
    input  wire logic        i_start,
    debug_reg_dump_if.master bus,
    output logic             o_busy,
    output logic             o_done
);
    localparam int c_NBYTES  = NB_DATA / NB_BYTE;
    localparam int c_NB_BCNT = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam int c_NB_WCNT = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_NB_BCNT-1:0] c_LAST_BYTE = c_NB_BCNT'(c_NBYTES - 1);
    localparam logic [c_NB_WCNT-1:0] c_LAST_WAIT = c_NB_WCNT'(READ_LATENCY - 1);
    localparam logic [NB_REG-1:0]    c_LAST_ADDR = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               r_state,    w_state;
    logic [NB_REG-1:0]    r_addr,     w_addr;
    logic                 r_ctrl,     w_ctrl;
    logic                 r_busy,     w_busy;
    logic                 r_valid,    w_valid;
    logic [NB_BYTE-1:0]   r_tx_data,  w_tx_data;
    logic [NB_DATA-1:0]   r_shift,    w_shift;
    logic [c_NB_BCNT-1:0] r_byte_cnt, w_byte_cnt;
    logic [c_NB_WCNT-1:0] r_wait_cnt, w_wait_cnt;
    logic [NB_DATA-1:0]   w_shifted;
    logic                 w_xfer;

    // Shifting the whole word keeps the next byte at the top, so the slice
    // stays legal even when a register is a single byte wide.
    assign w_shifted = r_shift << NB_BYTE;
    assign w_xfer    = r_valid & bus.i_tx_ready;

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_ctrl     = r_ctrl;
        w_busy     = r_busy;
        w_valid    = r_valid;
        w_tx_data  = r_tx_data;
        w_shift    = r_shift;
        w_byte_cnt = r_byte_cnt;
        w_wait_cnt = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state    = ST_WAIT;
                    w_addr     = '0;
                    w_ctrl     = 1'b1;
                    w_busy     = 1'b1;
                    w_wait_cnt = '0;
                end
            end
            ST_WAIT: begin
                w_wait_cnt = r_wait_cnt + 1'b1;
                if (r_wait_cnt == c_LAST_WAIT) begin
                    w_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_shift    = bus.i_data_reg_debug_unit;
                w_tx_data  = bus.i_data_reg_debug_unit[NB_DATA-1 -: NB_BYTE];
                w_byte_cnt = '0;
                w_valid    = 1'b1;
                w_state    = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (r_byte_cnt != c_LAST_BYTE) begin
                        w_shift    = w_shifted;
                        w_tx_data  = w_shifted[NB_DATA-1 -: NB_BYTE];
                        w_byte_cnt = r_byte_cnt + 1'b1;
                    end else begin
                        w_valid = 1'b0;
                        if (r_addr == c_LAST_ADDR) begin
                            w_state = ST_DONE;
                        end else begin
                            w_addr     = r_addr + 1'b1;
                            w_wait_cnt = '0;
                            w_state    = ST_WAIT;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_ctrl  = 1'b0;
                w_busy  = 1'b0;
                w_addr  = '0;
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_ctrl     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_tx_data  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_ctrl     <= w_ctrl;
            r_busy     <= w_busy;
            r_valid    <= w_valid;
            r_tx_data  <= w_tx_data;
            r_shift    <= w_shift;
            r_byte_cnt <= w_byte_cnt;
            r_wait_cnt <= w_wait_cnt;
        end
    end

    assign bus.o_ctrl_read_debug_reg = r_ctrl;
    assign bus.o_addr_debug_unit     = r_addr;
    assign bus.o_tx_valid            = r_valid;
    assign bus.o_tx_data             = r_tx_data;
    assign o_busy                    = r_busy;
    assign o_done                    = (r_state == ST_DONE);
endmodule
`default_nettype wire
